// File: rtl/lsu_align_pkg.sv
// Shared types, funct3 encodings and lane/size helpers for the load/store alignment unit.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD0  = 2'd1,
    LD1  = 2'd2,
    ST1  = 2'd3
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] sz);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return |off;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
    return ({2'b00, off} + {1'b0, size_bytes(sz)}) > 4'd4;
  endfunction

  // Low nibble is word A's lanes, high nibble spills into word B.
  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] sz);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Request/response and data-memory bus between the MEM stage, lsu_align and the memory.
interface lsu_align_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align_load_extend.sv
// Load data extraction: shifts {B,A} down to the addressed byte and sign/zero-extends.
module load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);
  logic [31:0] shifted;

  assign shifted = 32'(data_i >> {offset_i, 3'b000});

  always_comb begin
    result_o = shifted;
    case (funct3_i)
      LB:      result_o = {{24{shifted[7]}}, shifted[7:0]};
      LH:      result_o = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     result_o = {24'h0, shifted[7:0]};
      LHU:     result_o = {16'h0, shifted[15:0]};
      LW:      result_o = shifted;
      default: result_o = shifted;
    endcase
  end
endmodule

// File: rtl/lsu_align.sv
// RV32 load/store alignment unit in front of a word-addressed, one-cycle-read data memory.
// Define LSU_MISALIGN_EN to split word-crossing accesses; otherwise any misalignment errors.
// state | meaning
// IDLE  | ready; drives access A (or errors) straight from the live request
// LD0   | word A returning; finish, or issue read of word B
// LD1   | word B returning; finish split load
// ST1   | write of word B for a split store
module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        rst,
  lsu_align_if.slave bus
);
  localparam int WA_W = ADDR_W - 2;

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [63:0] ext_data;
  logic [31:0] ext_result;
  logic        req_err;
  logic [3:0]  req_lanes;

  assign req_lanes = 4'(lane_mask(bus.req_addr[1:0], bus.req_funct3[1:0]));

`ifdef LSU_MISALIGN_EN
  logic [WA_W-1:0] wa_q, wa_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     word_a_q, word_a_d;
  logic [3:0]      held_lanes_b;
  logic            req_split, held_split;

  assign req_err      = illegal_f3(bus.req_we, bus.req_funct3);
  assign req_split    = crosses(bus.req_addr[1:0], bus.req_funct3[1:0]);
  assign held_split   = crosses(off_q, f3_q[1:0]);
  assign held_lanes_b = 4'(lane_mask(off_q, f3_q[1:0]) >> 4);
  assign ext_data     = (state_q == LD1) ? {bus.mem_rdata, word_a_q} : {32'h0, bus.mem_rdata};
`else
  assign req_err  = illegal_f3(bus.req_we, bus.req_funct3) ||
                    misaligned(bus.req_addr[1:0], bus.req_funct3[1:0]);
  assign ext_data = {32'h0, bus.mem_rdata};
`endif

  load_extend u_load_extend (
    .data_i   (ext_data),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (ext_result)
  );

  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 4'h0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
`ifdef LSU_MISALIGN_EN
    wa_d     = wa_q;
    wdata_d  = wdata_q;
    word_a_d = word_a_q;
`endif
    // Memory strobes stay quiet while reset is held so an interrupted access cannot continue.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            f3_d  = bus.req_funct3;
            off_d = bus.req_addr[1:0];
`ifdef LSU_MISALIGN_EN
            wa_d    = bus.req_addr[ADDR_W-1:2];
            wdata_d = bus.req_wdata;
`endif
            if (req_err) begin
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
            end else begin
              mem_en   = 1'b1;
              mem_addr = 32'(bus.req_addr[ADDR_W-1:2]);
              if (bus.req_we) begin
                mem_we    = req_lanes;
                mem_wdata = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
`ifdef LSU_MISALIGN_EN
                if (req_split) state_d = ST1;
                else resp_valid_d = 1'b1;
`else
                resp_valid_d = 1'b1;
`endif
              end else begin
                state_d = LD0;
              end
            end
          end
        end
        LD0: begin
`ifdef LSU_MISALIGN_EN
          if (held_split) begin
            word_a_d = bus.mem_rdata;
            mem_en   = 1'b1;
            mem_addr = 32'(wa_q + WA_W'(1));
            state_d  = LD1;
          end else
`endif
          begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ext_result;
            state_d      = IDLE;
          end
        end
`ifdef LSU_MISALIGN_EN
        LD1: begin
          resp_valid_d = 1'b1;
          resp_rdata_d = ext_result;
          state_d      = IDLE;
        end
        ST1: begin
          mem_en       = 1'b1;
          mem_we       = held_lanes_b;
          mem_addr     = 32'(wa_q + WA_W'(1));
          mem_wdata    = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      f3_q         <= 3'h0;
      off_q        <= 2'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_EN
      wa_q     <= '0;
      wdata_q  <= 32'h0;
      word_a_q <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef LSU_MISALIGN_EN
      wa_q     <= wa_d;
      wdata_q  <= wdata_d;
      word_a_q <= word_a_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: directed requests push expected responses; a monitor pops on resp_valid.
module tb_lsu_align;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_align_if #(.ADDR_W(32)) bus ();
  lsu_align #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          t_last = 0;
  logic        s_en;
  logic [3:0]  s_we;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] mem [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory with byte enables and one-cycle registered read.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= mem[bus.mem_addr[5:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'h0, bus.resp_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("resp_cycle", cyc, e.due);
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic push, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat);
    int guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.req_ready) check("req_ready_wait", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    t_last = cyc;
    if (push) exp_q.push_back('{due: t_last + lat, rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    s_en    = bus.mem_en;
    s_we    = bus.mem_we;
    s_addr  = bus.mem_addr;
    s_wdata = bus.mem_wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic exp_err, input int lat);
    issue(1'b1, f3, addr, wdata, 1'b1, 32'h0, exp_err, lat);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_rdata,
                    input logic exp_err, input int lat);
    issue(1'b0, f3, addr, 32'h0, 1'b1, exp_rdata, exp_err, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int guard;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'h0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_mem_we", {28'h0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    @(posedge clk); #1;

    st(SW, 32'h10, 32'hDEADBEEF, 1'b0, 1);
    check("sw_en", {31'h0, s_en}, 32'h1);
    check("sw_we", {28'h0, s_we}, 32'hF);
    check("sw_addr", s_addr, 32'h4);
    check("sw_wdata", s_wdata, 32'hDEADBEEF);
    ld(LW, 32'h10, 32'hDEADBEEF, 1'b0, 2);
    check("lw_we", {28'h0, s_we}, 32'h0);
    check("lw_addr", s_addr, 32'h4);

    st(SB, 32'h13, 32'h00000080, 1'b0, 1);
    check("sb_we", {28'h0, s_we}, 32'h8);
    check("sb_wdata", s_wdata, 32'h80000000);
    ld(LB, 32'h13, 32'hFFFFFF80, 1'b0, 2);
    ld(LBU, 32'h13, 32'h00000080, 1'b0, 2);
    ld(LH, 32'h12, 32'hFFFF80AD, 1'b0, 2);
    ld(LHU, 32'h10, 32'h0000BEEF, 1'b0, 2);

    ld(3'b011, 32'h10, 32'h0, 1'b1, 1);
    check("ld_ill_en", {31'h0, s_en}, 32'h0);
    st(3'b100, 32'h10, 32'h12345678, 1'b1, 1);
    check("st_ill_en", {31'h0, s_en}, 32'h0);

    st(SW, 32'h20, 32'h01020304, 1'b0, 1);
    t1 = t_last;
    st(SW, 32'h24, 32'hA5A5A5A5, 1'b0, 1);
    check("b2b_accept", t_last, t1 + 1);
    st(SH, 32'h22, 32'h00005678, 1'b0, 1);
    check("sh_we", {28'h0, s_we}, 32'hC);
    check("sh_addr", s_addr, 32'h8);
    check("sh_wdata", s_wdata, 32'h56780000);
    ld(LW, 32'h20, 32'h56780304, 1'b0, 2);
    ld(LW, 32'h24, 32'hA5A5A5A5, 1'b0, 2);

`ifdef LSU_MISALIGN_EN
    st(SW, 32'h0E, 32'h11223344, 1'b0, 2);
    check("split_sw_a_we", {28'h0, s_we}, 32'hC);
    check("split_sw_a_addr", s_addr, 32'h3);
    check("split_sw_a_wdata", s_wdata, 32'h33440000);
    @(negedge clk);
    check("split_sw_b_en", {31'h0, bus.mem_en}, 32'h1);
    check("split_sw_b_we", {28'h0, bus.mem_we}, 32'h3);
    check("split_sw_b_addr", bus.mem_addr, 32'h4);
    check("split_sw_b_wdata", bus.mem_wdata, 32'h00001122);
    @(posedge clk); #1;
    ld(LW, 32'h0E, 32'h11223344, 1'b0, 3);
    check("split_lw_a_addr", s_addr, 32'h3);
    @(negedge clk);
    check("split_lw_b_en", {31'h0, bus.mem_en}, 32'h1);
    check("split_lw_b_addr", bus.mem_addr, 32'h4);
    @(posedge clk); #1;
    ld(LH, 32'h11, 32'hFFFFAD11, 1'b0, 2);
    @(negedge clk);
    check("lh_inword_single", {31'h0, bus.mem_en}, 32'h0);
    @(posedge clk); #1;
`else
    ld(LH, 32'h01, 32'h0, 1'b1, 1);
    check("lh_mis_en", {31'h0, s_en}, 32'h0);
    ld(LW, 32'h12, 32'h0, 1'b1, 1);
    check("lw_mis_en", {31'h0, s_en}, 32'h0);
    st(SH, 32'h13, 32'h0000BEEF, 1'b1, 1);
    check("sh_mis_en", {31'h0, s_en}, 32'h0);
`endif

    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_before_rst", exp_q.size(), 32'h0);

    issue(1'b0, LW, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("midrst_resp_valid0", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    check("midrst_resp_valid1", {31'h0, bus.resp_valid}, 32'h0);
    @(posedge clk); #1;

    ld(LW, 32'h10, 32'h80ADBEEF ^ (`ifdef LSU_MISALIGN_EN 32'h0000AFCD `else 32'h0 `endif), 1'b0, 2);

    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_final", exp_q.size(), 32'h0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit in the MEM stage of the pipelined RV32 core, directly upstream of the word-addressed data memory (byte write enables, one-cycle synchronous read). It accepts one byte-addressed load/store request at a time. For stores it generates the word address, the byte-lane write mask and the lane-shifted write data. For loads it extracts and sign- or zero-extends the addressed bytes from the returned word. Misaligned accesses that cross a word boundary are optionally split into two sequential memory accesses, and the pipeline is stalled through `req_ready` meanwhile.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: unit can accept; high only in IDLE.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: RV32 funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- `req_addr`, in, ADDR_W: byte address.
- `req_wdata`, in, 32: store data, right-aligned.
- `resp_valid`, out, 1: one-cycle completion pulse.
- `resp_rdata`, out, 32: extended load data; 0 for stores and errors.
- `resp_err`, out, 1: illegal funct3 or unsupported misalignment; qualified by `resp_valid`.
- `mem_en`, out, 1: memory enable.
- `mem_we`, out, 4: byte write enables.
- `mem_addr`, out, 32: word index `{2'b00, byte_addr[31:2]}`.
- `mem_wdata`, out, 32: lane-aligned write data.
- `mem_rdata`, in, 32: memory read word, valid the cycle after `mem_en`.

## Operation
- Size n = 1/2/4 bytes from `funct3[1:0]`. Offset o = `addr[1:0]`.
- An access is split when o+n>4. Split accesses use word A = `addr[31:2]` then word B = A+1, which wraps modulo 2^30.
- Illegal encodings:
  - Load funct3 011, 110 or 111.
  - Store funct3 with bit 2 set, or 011.
  - Result: no memory access, `resp_err`=1.
- Store lane rules:
  - Mask `m` = ((1<<n)-1) << o, 8 bits wide.
  - Access A: `mem_we`=m[3:0], `mem_wdata`=wdata<<8o.
  - Access B: `mem_we`=m[7:4], `mem_wdata`=wdata>>8(4-o).
- Load: form {B,A}, or {0,A} if not split. Shift right by 8o, keep the low n bytes, then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, `mem_en` and the access-A signals are driven combinationally from the request in the same cycle, and request fields are latched. Next state: aligned store → IDLE; split store → ST1; load → LD0; error → IDLE.
  - LD0: `mem_rdata` = word A. Not split: register the extended result → IDLE. Split: latch A, issue read of B → LD1.
  - LD1: `mem_rdata` = word B; register the combined result → IDLE.
  - ST1: issue the write of B → IDLE.
- `resp_valid` is registered and pulses in the cycle after the final state. A new request may be accepted in that same cycle (back-to-back).
- `mem_en`=0 and `mem_we`=0 in any cycle without an access. `mem_we`=0 on all loads.

## Timing
- Reset values: state IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_en` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0. `req_ready` is 1 after reset.
- Latency from accept cycle t:
  - Aligned store: resp at t+1.
  - Aligned load: resp at t+2.
  - Split store: resp at t+2.
  - Split load: resp at t+3.
  - Error: resp at t+1.
- Throughput: one aligned access every cycle for stores and every 2 cycles for loads.
- `rst` mid-operation: return to IDLE next edge, drop `mem_en`, no `resp_valid`. A split store interrupted after access A leaves A written. This is accepted; software-visible only on reset.
- `req_*` inputs are ignored while `req_ready`=0.

## Configuration
- `LSU_MISALIGN_EN` defined: word-crossing accesses are split as above. Misaligned accesses within one word (e.g. LH at o=1) complete in a single access.
- Undefined: any access with o not a multiple of n returns `resp_err`=1 after 1 cycle with no memory access. States LD1 and ST1 are not synthesized.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encodings: IDLE, LD0, LD1, ST1.
  - Size decode function.
- Sub-module `load_extend` (combinational): inputs 64-bit {B,A}, offset and funct3; output the 32-bit extended result.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `mem_we`=1111 and `mem_addr`=4 at t; LW resp 0xDEADBEEF at t+2.
- SB 0x80 to 0x13, then LB 0x13 and LBU 0x13 → `mem_we`=1000; LB resp 0xFFFFFF80, LBU resp 0x00000080.
- Illegal encodings:
  - Load funct3 011 → `resp_err`=1 at t+1, no `mem_en`.
  - Store funct3 100 → same response.
- With `LSU_MISALIGN_EN`:
  - SW 0x11223344 to 0x0E writes word 3 with mask 1100 and data 0x33440000, then word 4 with mask 0011 and data 0x00001122.
  - LW 0x0E returns 0x11223344 at t+3.
  - LH 0x01 completes in a single access.
- Without `LSU_MISALIGN_EN`: LH 0x01 → `resp_err`=1 at t+1, `mem_en` never high.
- Assert `rst` in LD0 of a load → no `resp_valid`, `req_ready`=1 the cycle after reset deasserts. Also check back-to-back SW accepted on consecutive cycles.
